// File: rtl/apb_clint_timer.sv
// APB machine timer: prescaled 64-bit mtime, NUM_CH 64-bit compare channels, registered interrupts.
// Optional periodic auto-reload with sticky pending STATUS is compiled in with `define TIMER_PERIODIC_EN.
module apb_clint_timer #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1100_0000,
    parameter int unsigned           NUM_CH     = 2,
    parameter int unsigned           PRESCALE   = 1000
) (
    input  logic                  APB_PCLK,
    input  logic                  APB_PRESETn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    output logic [NUM_CH-1:0]     timer_interrupt
);

    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [15:0]       pcnt_q, pcnt_d;
    logic [63:0]       mtime_q, mtime_d;
    logic [63:0]       cmp_q [NUM_CH];
    logic [63:0]       cmp_d [NUM_CH];
    logic              en_q, en_d;
    logic              pready_q, perr_q;
    logic [NUM_CH-1:0] irq_q, irq_d;
    logic [NUM_CH-1:0] hit;
    logic              tick;
`ifdef TIMER_PERIODIC_EN
    logic [31:0]       period_q [NUM_CH];
    logic [31:0]       period_d [NUM_CH];
    logic [NUM_CH-1:0] status_q, status_d;
    logic [NUM_CH-1:0] status_set, status_clr;
`endif

    logic [15:0]       off;
    logic              base_hit, aligned, valid, access, wr_en;
    logic [NUM_CH-1:0] sel_cmp_lo, sel_cmp_hi, sel_period;
    logic              sel_mt_lo, sel_mt_hi, sel_ctrl, sel_status;
    logic [31:0]       wdata, rdata;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] res;
        for (int unsigned b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign off      = paddr[15:0];
    assign base_hit = (paddr[ADDR_WIDTH-1:16] == BASE_ADDR[ADDR_WIDTH-1:16]);
    assign aligned  = (off[1:0] == 2'b00);
    assign wdata    = pdata[31:0];

    always_comb begin
        sel_cmp_lo = '0;
        sel_cmp_hi = '0;
        sel_period = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            sel_cmp_lo[n] = base_hit & aligned & ~off[15] & (off[14:3] == 12'(n)) & ~off[2];
            sel_cmp_hi[n] = base_hit & aligned & ~off[15] & (off[14:3] == 12'(n)) &  off[2];
            sel_period[n] = base_hit & aligned & (off[15:14] == 2'b10) & (off[13:2] == 12'(n));
        end
    end

    assign sel_mt_lo  = base_hit & (off == 16'hBFF8);
    assign sel_mt_hi  = base_hit & (off == 16'hBFFC);
    assign sel_ctrl   = base_hit & (off == 16'hC000);
    assign sel_status = base_hit & (off == 16'hC004);
    assign valid      = (|sel_cmp_lo) | (|sel_cmp_hi) | (|sel_period) |
                        sel_mt_lo | sel_mt_hi | sel_ctrl | sel_status;

    // Single wait state: the first access cycle registers pready and commits the write.
    assign access = psel & penable & ~pready_q;
    assign wr_en  = access & pwrite & valid;

    always_comb begin
        rdata = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (sel_cmp_lo[n]) rdata = cmp_q[n][31:0];
            if (sel_cmp_hi[n]) rdata = cmp_q[n][63:32];
`ifdef TIMER_PERIODIC_EN
            if (sel_period[n]) rdata = period_q[n];
`endif
        end
`ifdef TIMER_PERIODIC_EN
        if (sel_status) rdata = 32'(status_q);
`endif
        if (sel_mt_lo) rdata = mtime_q[31:0];
        if (sel_mt_hi) rdata = mtime_q[63:32];
        if (sel_ctrl)  rdata = {31'b0, en_q};
    end

    assign prdata          = rdata;
    assign pready          = pready_q;
    assign perr            = perr_q;
    assign timer_interrupt = irq_q;

    assign tick = en_q & (pcnt_q == PCNT_MAX);

    always_comb begin
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            hit[n] = (mtime_q >= cmp_q[n]);
        end
    end

    always_comb begin
        pcnt_d = pcnt_q;
        if (en_q) pcnt_d = tick ? '0 : pcnt_q + 16'd1;

        en_d = en_q;
        if (wr_en & sel_ctrl & pstb[0]) en_d = wdata[0];

        // An MTIME write replaces the increment; the untouched half keeps its pre-tick value.
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_en & sel_mt_lo) mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wdata, pstb)};
        if (wr_en & sel_mt_hi) mtime_d = {merge(mtime_q[63:32], wdata, pstb), mtime_q[31:0]};

`ifdef TIMER_PERIODIC_EN
        status_set = '0;
        status_clr = (wr_en & sel_status & pstb[0]) ? wdata[NUM_CH-1:0] : '0;
`endif
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            cmp_d[n] = cmp_q[n];
`ifdef TIMER_PERIODIC_EN
            period_d[n] = period_q[n];
            if (tick & hit[n] & (period_q[n] != 32'd0)) begin
                cmp_d[n]      = cmp_q[n] + {32'b0, period_q[n]};
                status_set[n] = 1'b1;
            end
            if (wr_en & sel_period[n]) period_d[n] = merge(period_q[n], wdata, pstb);
            irq_d[n] = status_q[n] | (hit[n] & (period_q[n] == 32'd0));
`else
            irq_d[n] = hit[n];
`endif
            if (wr_en & sel_cmp_lo[n]) cmp_d[n] = {cmp_q[n][63:32], merge(cmp_q[n][31:0], wdata, pstb)};
            if (wr_en & sel_cmp_hi[n]) cmp_d[n] = {merge(cmp_q[n][63:32], wdata, pstb), cmp_q[n][31:0]};
        end
`ifdef TIMER_PERIODIC_EN
        status_d = (status_q & ~status_clr) | status_set;
`endif
    end

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            pready_q <= 1'b0;
            perr_q   <= 1'b0;
            irq_q    <= '0;
            pcnt_q   <= '0;
            mtime_q  <= '0;
            en_q     <= 1'b1;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                cmp_q[n] <= '1;
`ifdef TIMER_PERIODIC_EN
                period_q[n] <= '0;
`endif
            end
`ifdef TIMER_PERIODIC_EN
            status_q <= '0;
`endif
        end else begin
            pready_q <= access;
            perr_q   <= access & ~valid;
            irq_q    <= irq_d;
            pcnt_q   <= pcnt_d;
            mtime_q  <= mtime_d;
            en_q     <= en_d;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                cmp_q[n] <= cmp_d[n];
`ifdef TIMER_PERIODIC_EN
                period_q[n] <= period_d[n];
`endif
            end
`ifdef TIMER_PERIODIC_EN
            status_q <= status_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_clint_timer.sv
// Self-checking bench for apb_clint_timer (PRESCALE=4, NUM_CH=2); APB reads go through a scoreboard queue.
module tb_apb_clint_timer;

    localparam logic [31:0] BASE = 32'h1100_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pdata = '0;
    logic [31:0] prdata;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  pstb = '0;
    logic        pready, perr;
    logic [1:0]  timer_interrupt;

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   acc_cnt = 0;
    exp_t exp_q[$];

    apb_clint_timer #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BASE_ADDR (32'h1100_0000),
        .NUM_CH    (2),
        .PRESCALE  (4)
    ) dut (
        .APB_PCLK       (clk),
        .APB_PRESETn    (rst_n),
        .paddr          (paddr),
        .pdata          (pdata),
        .prdata         (prdata),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .pstb           (pstb),
        .pready         (pready),
        .perr           (perr),
        .timer_interrupt(timer_interrupt)
    );

    always #5 clk = ~clk;

    // Count of rising edges since reset release; ticks land on multiples of 4 while EN stays 1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scoreboard consumer: one pop per completed transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            acc_cnt = 0;
        end else if (pready) begin
            checks++;
            if (acc_cnt != 1) begin
                errors++;
                $display("FAIL wait_states addr=%h got %0d want 1", paddr, acc_cnt);
            end
            acc_cnt = 0;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pready addr=%h got pready=1 want no transfer", paddr);
            end else begin
                e = exp_q.pop_front();
                if (((prdata & e.mask) !== (e.data & e.mask)) || (perr !== e.err)) begin
                    errors++;
                    $display("FAIL apb_resp addr=%h got data=%h perr=%b want data=%h (mask %h) perr=%b",
                             e.addr, prdata, perr, e.data, e.mask, e.err);
                end
            end
        end else if (psel && penable) begin
            acc_cnt++;
        end
    end

    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [31:0] exp_d, input logic [31:0] mask,
                       input logic exp_e, output logic [31:0] rd);
        exp_t e;
        int   n;
        e.addr = addr; e.data = exp_d; e.mask = mask; e.err = exp_e;
        exp_q.push_back(e);
        paddr = addr; pdata = wdata; pstb = strb; pwrite = wr;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!pready && n < 16);
        rd = prdata;
        if (!pready) begin
            checks++;
            errors++;
            $display("FAIL apb_timeout addr=%h got no pready want pready within 16 cycles", addr);
        end
        @(negedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd32(input logic [31:0] addr, input logic [31:0] exp_d, input logic [31:0] mask,
                        input logic exp_e, output logic [31:0] v);
        apb(1'b0, addr, 32'h0, 4'h0, exp_d, mask, exp_e, v);
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                        input logic exp_e);
        logic [31:0] dummy;
        apb(1'b1, addr, data, strb, 32'h0, 32'h0, exp_e, dummy);
    endtask

    task automatic do_reset();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pready !== 1'b0 || perr !== 1'b0 || timer_interrupt !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs got pready=%b perr=%b irq=%b want 0 0 00", pready, perr, timer_interrupt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd32(BASE + 32'hBFF8, 32'h0, '1, 1'b0, v);
        rd32(BASE + 32'hBFFC, 32'h0, '1, 1'b0, v);
        rd32(BASE + 32'h0000, 32'hFFFF_FFFF, '1, 1'b0, v);
        rd32(BASE + 32'h000C, 32'hFFFF_FFFF, '1, 1'b0, v);
        rd32(BASE + 32'hC000, 32'h1, '1, 1'b0, v);
        checks++;
        if (timer_interrupt !== 2'b00) begin
            errors++;
            $display("FAIL reset_irq got %b want 00", timer_interrupt);
        end
        // Reset while pready is high must drop it without waiting for a clock edge.
        paddr = BASE + 32'hC000; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (pready !== 1'b1) begin
            errors++;
            $display("FAIL midxfer_pready got %b want 1", pready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (pready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_pready got %b want 0", pready);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_match_timing();
        logic [31:0] v;
        do_reset();
        wr32(BASE + 32'h0004, 32'h0, 4'hF, 1'b0);
        wr32(BASE + 32'h0000, 32'h3, 4'hF, 1'b0);
        wait_cyc(12);
        checks++;
        if (timer_interrupt[0] !== 1'b0) begin
            errors++;
            $display("FAIL irq0_before_match cyc=%0d got %b want 0", cyc, timer_interrupt[0]);
        end
        wait_cyc(13);
        checks++;
        if (timer_interrupt !== 2'b01) begin
            errors++;
            $display("FAIL irq_at_match cyc=%0d got %b want 01", cyc, timer_interrupt);
        end
        rd32(BASE + 32'hBFF8, 32'h3, '1, 1'b0, v);
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        int          e, t;
        wr32(BASE + 32'h0000, 32'h5, 4'hF, 1'b0);
        wr32(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0);
        wr32(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
        e = cyc;
        t = (e / 4 + 1) * 4;
        wait_cyc(t);
        checks++;
        if (timer_interrupt !== 2'b11) begin
            errors++;
            $display("FAIL irq_at_all_ones cyc=%0d got %b want 11", cyc, timer_interrupt);
        end
        wait_cyc(t + 1);
        checks++;
        if (timer_interrupt !== 2'b00) begin
            errors++;
            $display("FAIL irq_after_wrap cyc=%0d got %b want 00", cyc, timer_interrupt);
        end
        rd32(BASE + 32'hBFFC, 32'h0, '1, 1'b0, v);
    endtask

    task automatic test_tick_write();
        logic [31:0] v;
        int          guard = 0;
        while ((cyc % 4) != 2 && guard < 8) begin
            @(posedge clk); #1;
            guard++;
        end
        wr32(BASE + 32'hBFF8, 32'h1234_5678, 4'hF, 1'b0);
        rd32(BASE + 32'hBFF8, 32'h1234_5678, '1, 1'b0, v);
        rd32(BASE + 32'hBFFC, 32'h0, '1, 1'b0, v);
    endtask

    task automatic test_enable();
        logic [31:0] v1, v2, v3;
        wr32(BASE + 32'hC000, 32'h0, 4'hF, 1'b0);
        rd32(BASE + 32'hBFF8, 32'h0, 32'h0, 1'b0, v1);
        repeat (100) @(posedge clk);
        #1;
        rd32(BASE + 32'hBFF8, 32'h0, 32'h0, 1'b0, v2);
        checks++;
        if (v2 !== v1) begin
            errors++;
            $display("FAIL en0_frozen got %h want %h", v2, v1);
        end
        rd32(BASE + 32'hC000, 32'h0, '1, 1'b0, v3);
        wr32(BASE + 32'hC000, 32'h1, 4'hF, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        rd32(BASE + 32'hBFF8, 32'h0, 32'h0, 1'b0, v3);
        checks++;
        if (!(v3 > v1)) begin
            errors++;
            $display("FAIL en1_counts got %h want > %h", v3, v1);
        end
    endtask

    task automatic test_errors();
        logic [31:0] v;
        rd32(BASE + 32'hC008, 32'h0, '1, 1'b1, v);
        rd32(BASE + 32'h0010, 32'h0, '1, 1'b1, v);
        wr32(BASE + 32'h0010, 32'h0, 4'hF, 1'b1);
        wr32(BASE + 32'h0014, 32'h0, 4'hF, 1'b1);
        rd32(BASE + 32'h0010, 32'h0, '1, 1'b1, v);
        rd32(BASE + 32'h0008, 32'hFFFF_FFFF, '1, 1'b0, v);
        rd32(BASE + 32'h000C, 32'hFFFF_FFFF, '1, 1'b0, v);
        rd32(BASE + 32'h0000, 32'h5, '1, 1'b0, v);
        rd32(32'h1200_0000, 32'h0, '1, 1'b1, v);
        rd32(BASE + 32'h0001, 32'h0, '1, 1'b1, v);
    endtask

    task automatic test_strobe();
        logic [31:0] v;
        wr32(BASE + 32'h0000, 32'hAABB_CCDD, 4'b0010, 1'b0);
        rd32(BASE + 32'h0000, 32'h0000_CC05, '1, 1'b0, v);
        wr32(BASE + 32'h0000, 32'h1122_3344, 4'b1001, 1'b0);
        rd32(BASE + 32'h0000, 32'h1100_CC44, '1, 1'b0, v);
        rd32(BASE + 32'h0004, 32'h0, '1, 1'b0, v);
    endtask

`ifdef TIMER_PERIODIC_EN
    task automatic test_periodic();
        logic [31:0] v;
        int          guard;
        wr32(BASE + 32'hC000, 32'h0, 4'hF, 1'b0);
        wr32(BASE + 32'hBFFC, 32'h0, 4'hF, 1'b0);
        wr32(BASE + 32'hBFF8, 32'h0, 4'hF, 1'b0);
        wr32(BASE + 32'h0000, 32'h2, 4'hF, 1'b0);
        wr32(BASE + 32'h8000, 32'h3, 4'hF, 1'b0);
        rd32(BASE + 32'h8000, 32'h3, '1, 1'b0, v);
        wr32(BASE + 32'hC004, 32'hFF, 4'hF, 1'b0);
        wr32(BASE + 32'hC000, 32'h1, 4'hF, 1'b0);
        repeat (60) @(posedge clk);
        #1;
        rd32(BASE + 32'hC004, 32'h1, '1, 1'b0, v);
        rd32(BASE + 32'h0000, 32'h0, 32'h0, 1'b0, v);
        checks++;
        if (v < 32'd5 || ((v - 32'd2) % 32'd3) != 0) begin
            errors++;
            $display("FAIL periodic_cmp got %0d want 5,8,11,...", v);
        end
        checks++;
        if (timer_interrupt !== 2'b01) begin
            errors++;
            $display("FAIL periodic_irq got %b want 01", timer_interrupt);
        end
        wr32(BASE + 32'hC000, 32'h0, 4'hF, 1'b0);
        wr32(BASE + 32'hC004, 32'h1, 4'hF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (timer_interrupt[0] !== 1'b0) begin
            errors++;
            $display("FAIL status_clear_irq got %b want 0", timer_interrupt[0]);
        end
        wr32(BASE + 32'hC000, 32'h1, 4'hF, 1'b0);
        guard = 0;
        while (timer_interrupt[0] !== 1'b1 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (timer_interrupt[0] !== 1'b1) begin
            errors++;
            $display("FAIL periodic_rearm got %b want 1 within 40 cycles", timer_interrupt[0]);
        end
    endtask
`else
    task automatic test_no_periodic();
        logic [31:0] v;
        rd32(BASE + 32'h8000, 32'h0, '1, 1'b0, v);
        wr32(BASE + 32'h8000, 32'h7, 4'hF, 1'b0);
        rd32(BASE + 32'h8000, 32'h0, '1, 1'b0, v);
        rd32(BASE + 32'h8004, 32'h0, '1, 1'b0, v);
        rd32(BASE + 32'h8008, 32'h0, '1, 1'b1, v);
        wr32(BASE + 32'hC004, 32'hFF, 4'hF, 1'b0);
        rd32(BASE + 32'hC004, 32'h0, '1, 1'b0, v);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_match_timing();
        test_wrap();
        test_tick_write();
        test_enable();
        test_errors();
        test_strobe();
`ifdef TIMER_PERIODIC_EN
        test_periodic();
`else
        test_no_periodic();
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
